// File: rtl/spi_xfer_seq.sv
// Streaming front end for an SPI host core: programs divider/SS/TX/CTRL per request,
// waits for the completion interrupt, reads RX back and returns it on a response channel.
module spi_xfer_seq #(
  parameter int         SS_NB       = 8,
  parameter logic [7:0] ADDR_RX     = 8'h00,
  parameter logic [7:0] ADDR_TX     = 8'h00,
  parameter logic [7:0] ADDR_CTRL   = 8'h10,
  parameter logic [7:0] ADDR_DIV    = 8'h14,
  parameter logic [7:0] ADDR_SS     = 8'h18,
  parameter int         CTRL_GO_BIT = 8,
  parameter int         CTRL_IE_BIT = 12,
  parameter int         TIMEOUT     = 65535
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [31:0]      req_data_i,
  input  logic [6:0]       req_len_i,
  input  logic [SS_NB-1:0] req_ss_i,
  input  logic [15:0]      cfg_div_i,
  input  logic [15:0]      cfg_ctrl_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  output logic             rsp_err_o,
  output logic             busy_o,
  output logic [7:0]       core_addr_o,
  output logic [31:0]      core_wdata_o,
  output logic [3:0]       core_be_o,
  output logic             core_we_o,
  output logic             core_re_o,
  input  logic [31:0]      core_rdata_i,
  input  logic             core_intr_tx_i,
  input  logic             core_intr_rx_i
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_DIV, S_WR_SS, S_WR_TX, S_WR_CTRL, S_WAIT,
    S_SETTLE1, S_SETTLE2, S_RD_RX, S_RD_CAP, S_RSP
  } state_t;

  state_t           state_r, next_s;
  logic [31:0]      data_r;
  logic [6:0]       len_r;
  logic [SS_NB-1:0] ss_r;
  logic [CNT_W-1:0] cnt_r;
  logic             intr_s, cnt_last_s;

  logic [15:0]      ctrl_s;
  logic [7:0]       addr_s;
  logic [31:0]      wdata_s;
  logic             we_s, re_s;

  logic             req_ready_r, rsp_valid_r, rsp_err_r, busy_r, we_r, re_r;
  logic [31:0]      rsp_data_r, wdata_r;
  logic [7:0]       addr_r;
  logic [3:0]       be_r;

  assign intr_s     = core_intr_tx_i | core_intr_rx_i;
  assign cnt_last_s = (cnt_r == CNT_LAST);

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_IDLE:    if (req_valid_i) next_s = S_WR_DIV; else next_s = S_IDLE;
      S_WR_DIV:  next_s = S_WR_SS;
      S_WR_SS:   next_s = S_WR_TX;
      S_WR_TX:   next_s = S_WR_CTRL;
      S_WR_CTRL: next_s = S_WAIT;
      S_WAIT: begin
        // an interrupt on the last count still wins over the timeout
        if (intr_s)          next_s = S_SETTLE1;
        else if (cnt_last_s) next_s = S_RSP;
        else                 next_s = S_WAIT;
      end
      S_SETTLE1: next_s = S_SETTLE2;
      S_SETTLE2: next_s = S_RD_RX;
      S_RD_RX:   next_s = S_RD_CAP;
      S_RD_CAP:  next_s = S_RSP;
      S_RSP:     if (rsp_ready_i) next_s = S_IDLE; else next_s = S_RSP;
      default:   next_s = S_IDLE;
    endcase
  end

  // Core bus decode of the state being entered
  always_comb begin
    ctrl_s              = cfg_ctrl_i;
    ctrl_s[6:0]         = len_r;
    ctrl_s[CTRL_GO_BIT] = 1'b1;
    ctrl_s[CTRL_IE_BIT] = 1'b1;
    addr_s  = 8'h00;
    wdata_s = 32'h0000_0000;
    we_s    = 1'b0;
    re_s    = 1'b0;
    case (next_s)
      S_WR_DIV:  begin we_s = 1'b1; addr_s = ADDR_DIV;  wdata_s = {16'h0000, cfg_div_i}; end
      S_WR_SS:   begin we_s = 1'b1; addr_s = ADDR_SS;   wdata_s = 32'(ss_r); end
      S_WR_TX:   begin we_s = 1'b1; addr_s = ADDR_TX;   wdata_s = data_r; end
      S_WR_CTRL: begin we_s = 1'b1; addr_s = ADDR_CTRL; wdata_s = {16'h0000, ctrl_s}; end
      S_RD_RX:   begin re_s = 1'b1; addr_s = ADDR_RX; end
      default:   begin we_s = 1'b0; re_s = 1'b0; end
    endcase
  end

  // State, request latch, timeout counter and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= S_IDLE;
      data_r      <= 32'h0000_0000;
      len_r       <= 7'd0;
      ss_r        <= '0;
      cnt_r       <= '0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      addr_r      <= 8'h00;
      wdata_r     <= 32'h0000_0000;
      be_r        <= 4'h0;
      we_r        <= 1'b0;
      re_r        <= 1'b0;
    end else begin
      state_r <= next_s;
      if (state_r == S_IDLE && req_valid_i) begin
        data_r <= req_data_i;
        len_r  <= req_len_i;
        ss_r   <= req_ss_i;
      end
      if (state_r == S_WAIT) cnt_r <= cnt_r + CNT_W'(1);
      else                   cnt_r <= '0;
      req_ready_r <= (next_s == S_IDLE);
      busy_r      <= (next_s != S_IDLE);
      rsp_valid_r <= (next_s == S_RSP);
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      we_r        <= we_s;
      re_r        <= re_s;
      be_r        <= (we_s | re_s) ? 4'hF : 4'h0;
      if (state_r == S_RD_CAP) begin
        rsp_data_r <= core_rdata_i;
        rsp_err_r  <= 1'b0;
      end else if (state_r == S_WAIT && next_s == S_RSP) begin
        rsp_data_r <= 32'h0000_0000;
        rsp_err_r  <= 1'b1;
      end
    end
  end

  assign req_ready_o  = req_ready_r;
  assign rsp_valid_o  = rsp_valid_r;
  assign rsp_data_o   = rsp_data_r;
  assign rsp_err_o    = rsp_err_r;
  assign busy_o       = busy_r;
  assign core_addr_o  = addr_r;
  assign core_wdata_o = wdata_r;
  assign core_be_o    = be_r;
  assign core_we_o    = we_r;
  assign core_re_o    = re_r;

endmodule

// File: doc/spi_xfer_seq.md
Name: spi_xfer_seq

Overview:
Transfer sequencer that sits directly upstream of the SPI host core and drives that core's register bus. It accepts one SPI transfer per valid/ready request (TX word, char length, slave mask) and programs the core's divider, SS, TX and CTRL(GO) registers. It then waits for the core's completion interrupt, reads the RX register and returns the received word on a valid/ready response channel. Software or a DMA engine therefore sees a streaming word interface instead of polling core registers.

Parameters:
SS_NB, 8, slave-select width; matches the core's SS register
ADDR_RX, 8'h00, core RX_0 byte address
ADDR_TX, 8'h00, core TX_0 byte address
ADDR_CTRL, 8'h10, core CTRL byte address
ADDR_DIV, 8'h14, core DIVIDER byte address
ADDR_SS, 8'h18, core SS byte address
CTRL_GO_BIT, 8, GO bit index in CTRL
CTRL_IE_BIT, 12, interrupt-enable bit index in CTRL
TIMEOUT, 65535, maximum WAIT cycles before an error response

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
req_valid_i  in  1  transfer request valid
req_ready_o  out  1  request accepted when valid&ready
req_data_i  in  32  TX word
req_len_i  in  7  char length written to CTRL[6:0] (0 = 128 bits)
req_ss_i  in  SS_NB  slave-select mask
cfg_div_i  in  16  clock divider value
cfg_ctrl_i  in  16  static CTRL bits (edges, LSB, ASS, RX/TX select)
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_data_o  out  32  received word
rsp_err_o  out  1  1 = timeout; data is invalid
busy_o  out  1  high whenever state != IDLE
core_addr_o  out  8  core register address
core_wdata_o  out  32  core write data
core_be_o  out  4  byte enables; always 4'hF when we or re is high, else 0
core_we_o  out  1  core write strobe
core_re_o  out  1  core read strobe
core_rdata_i  in  32  core read data; registered in the core, valid 1 cycle after re
core_intr_tx_i  in  1  core TX-done pulse
core_intr_rx_i  in  1  core RX-done pulse

Behaviour:
- Reset (async, rst_i=1): state IDLE. All outputs are 0 except req_ready_o=1 (IDLE). Latched request and timeout counter are cleared.
- FSM states, one cycle each unless noted: IDLE -> WR_DIV -> WR_SS -> WR_TX -> WR_CTRL -> WAIT -> SETTLE1 -> SETTLE2 -> RD_RX -> RD_CAP -> RSP -> IDLE.
- IDLE: req_ready_o=1. On valid&ready, latch data/len/ss and go to WR_DIV. In all other states req_ready_o=0.
- Bus outputs are a registered decode of the next state. Each strobe is high for exactly the one cycle the FSM is in that state.
  - WR_DIV: we=1, addr=ADDR_DIV, wdata={16'b0,cfg_div_i}.
  - WR_SS: we=1, addr=ADDR_SS, wdata=zero-extended ss.
  - WR_TX: we=1, addr=ADDR_TX, wdata=latched data.
  - WR_CTRL: we=1, addr=ADDR_CTRL, wdata={16'b0, cfg_ctrl_i with [6:0]=len, GO bit=1, IE bit=1}.
  - RD_RX: re=1, we=0, addr=ADDR_RX.
  - cfg_* inputs are sampled in the cycle they are written.
- WAIT: timeout counter starts at 0 and increments each cycle.
  - core_intr_tx_i|core_intr_rx_i -> SETTLE1.
  - Counter reaches TIMEOUT-1 without a pulse -> RSP with rsp_err_o=1 and rsp_data_o=0. The RX read is skipped.
  - A pulse in the same cycle as the count reaches TIMEOUT-1 counts as success.
  - Pulses outside WAIT are ignored.
- SETTLE1/2: two idle cycles so the core's RX shift register is stable before the read.
- RD_CAP: rsp_data_o <= core_rdata_i, rsp_err_o <= 0.
- RSP: rsp_valid_o=1 and held with stable data until rsp_ready_i. Then go to IDLE and drop rsp_valid_o the next cycle. A new request is not accepted in the RSP->IDLE cycle, so back-to-back transfers have at least 1 idle cycle.
- Latency: accept at cycle 0; WR_CTRL at cycle 4. Interrupt seen at cycle D -> rsp_valid_o high at D+5.
- busy_o = (state != IDLE).
- Reset mid-operation: return to IDLE immediately and deassert all strobes and rsp_valid_o. No recovery of the core state is attempted.
- Never assert core_we_o and core_re_o together.

Test Plan:
- Single transfer: div=4, len=8, ss=8'h01, data=32'hA5, core echo model returns 32'h5A; intr at cycle 40 -> writes to 0x14=4, 0x18=1, 0x00=A5, then CTRL with GO and IE set and [6:0]=8 in cycles 1-4; rsp_valid at cycle 45, rsp_data=32'h5A, err=0.
- Back-pressure: hold rsp_ready_i=0 for 10 cycles -> rsp_valid_o and rsp_data_o stay stable; req_ready_o=0 throughout; accepted on ready, IDLE next cycle.
- Back-to-back: two requests queued (data 32'h11, 32'h22) -> second accepted exactly 1 cycle after first RSP handshake; responses in order.
- Timeout: TIMEOUT=16, no intr -> rsp_valid 16 cycles after WAIT entry, rsp_err_o=1, rsp_data_o=0, core_re_o never asserted.
- Reset mid-WAIT: assert rst_i asynchronously -> all strobes and rsp_valid_o drop in the same cycle, req_ready_o=1 after release; a stale intr pulse in IDLE causes no response.
- Intr_rx-only completion (RX-only ctrl config): core_intr_rx_i pulse alone -> completes normally with the read data.
